hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 71 +++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble and forwarding control for a 5-stage MIPS pipeline,
// including the HI/LO interlock for a multicycle divider.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_wreg,
    input  logic [4:0] id_rn,
    input  logic       id_is_load,
    input  logic       id_is_branch,
    input  logic       id_is_div,
    input  logic       id_is_hilo,
    output logic       stall,
    output logic       bubble_ex,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic [4:0] exe_reg,
    output logic [4:0] mem_reg,
    output logic       div_busy
);
    logic       ex_wreg, ex_load, mem_wreg, mem_load;
    logic [4:0] ex_rn, mem_rn;
    logic [5:0] div_cnt;
    logic       ex_rs, ex_rt, mem_rs, mem_rt;
    logic       ex_used, mem_used, load_use, branch_haz, div_haz, accept;
    always_comb begin
        ex_rs      = ex_wreg && ex_rn == id_rs && ex_rn != 5'd0;
        ex_rt      = ex_wreg && ex_rn == id_rt && ex_rn != 5'd0;
        mem_rs     = mem_wreg && mem_rn == id_rs && mem_rn != 5'd0;
        mem_rt     = mem_wreg && mem_rn == id_rt && mem_rn != 5'd0;
        ex_used    = (ex_rs && id_use_rs) || (ex_rt && id_use_rt);
        mem_used   = (mem_rs && id_use_rs) || (mem_rt && id_use_rt);
        div_busy   = div_cnt != 6'd0;
        load_use   = ex_load && ex_used;
        branch_haz = id_is_branch && (ex_used || (mem_load && mem_used));
        div_haz    = div_busy && (id_is_div || id_is_hilo);
        stall      = id_valid && (load_use || branch_haz || div_haz);
        bubble_ex  = stall;
        accept     = id_valid && !stall;
        // EX wins over MEM because it holds the youngest value; a load in EX has no data yet
        fwda       = (ex_rs && !ex_load) ? 2'b01 : mem_rs ? {1'b1, mem_load} : 2'b00;
        fwdb       = (ex_rt && !ex_load) ? 2'b01 : mem_rt ? {1'b1, mem_load} : 2'b00;
        exe_reg    = ex_wreg ? ex_rn : 5'd0;
        mem_reg    = mem_wreg ? mem_rn : 5'd0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_wreg  <= 1'b0;
            ex_rn    <= 5'd0;
            ex_load  <= 1'b0;
            mem_wreg <= 1'b0;
            mem_rn   <= 5'd0;
            mem_load <= 1'b0;
            div_cnt  <= 6'd0;
        end else begin
            ex_wreg  <= accept && id_wreg;
            ex_rn    <= accept ? id_rn : 5'd0;
            ex_load  <= accept && id_is_load;
            mem_wreg <= ex_wreg;
            mem_rn   <= ex_rn;
            mem_load <= ex_load;
            div_cnt  <= (accept && id_is_div) ? 6'(DIV_CYCLES) : div_busy ? div_cnt - 6'd1 : div_cnt;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic against an
// instruction-history reference model of the hazard unit.
module tb_hazard_ctrl;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0;
    logic       id_is_load = 1'b0, id_is_branch = 1'b0, id_is_div = 1'b0, id_is_hilo = 1'b0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rn = 5'd0;
    logic       stall, bubble_ex, div_busy;
    logic [1:0] fwda, fwdb;
    logic [4:0] exe_reg, mem_reg;

    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl #(.DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_rn(id_rn),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch), .id_is_div(id_is_div),
        .id_is_hilo(id_is_hilo), .stall(stall), .bubble_ex(bubble_ex), .fwda(fwda),
        .fwdb(fwdb), .exe_reg(exe_reg), .mem_reg(mem_reg), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    // Reference model: history of what entered EX on each edge, and the cycle the divider frees up
    typedef struct packed {logic w; logic [4:0] rn; logic ld;} rec_t;
    rec_t hist[$];
    int   cyc = 0;
    int   div_end = 0;

    function automatic rec_t stage(input int i);
        return hist.size() > i ? hist[i] : rec_t'(7'd0);
    endfunction

    function automatic logic hit(input rec_t r, input logic [4:0] s);
        return r.w && r.rn == s && s != 5'd0;
    endfunction

    function automatic logic used_hit(input rec_t r);
        return (id_use_rs && hit(r, id_rs)) || (id_use_rt && hit(r, id_rt));
    endfunction

    function automatic logic m_busy();
        return cyc < div_end;
    endfunction

    function automatic logic m_stall();
        rec_t e = stage(0);
        rec_t m = stage(1);
        logic lu = e.ld && used_hit(e);
        logic br = id_is_branch && (used_hit(e) || (m.ld && used_hit(m)));
        logic dv = m_busy() && (id_is_div || id_is_hilo);
        return id_valid && (lu || br || dv);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] s);
        rec_t e = stage(0);
        rec_t m = stage(1);
        if (hit(e, s) && !e.ld) return 2'd1;
        if (hit(m, s)) return m.ld ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [4:0] m_reg(input int i);
        rec_t r = stage(i);
        return r.w ? r.rn : 5'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist.delete();
            cyc = 0;
            div_end = 0;
        end else begin
            logic acc;
            rec_t r;
            acc = id_valid && !m_stall();
            r = acc ? rec_t'({id_wreg, id_rn, id_is_load}) : rec_t'(7'd0);
            hist.push_front(r);
            if (hist.size() > 2) void'(hist.pop_back());
            cyc++;
            if (acc && id_is_div) div_end = cyc + DIV;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_stall", {7'd0, stall}, {7'd0, m_stall()});
        chk("cmp_bubble", {7'd0, bubble_ex}, {7'd0, m_stall()});
        chk("cmp_fwda", {6'd0, fwda}, {6'd0, m_fwd(id_rs)});
        chk("cmp_fwdb", {6'd0, fwdb}, {6'd0, m_fwd(id_rt)});
        chk("cmp_exe_reg", {3'd0, exe_reg}, {3'd0, m_reg(0)});
        chk("cmp_mem_reg", {3'd0, mem_reg}, {3'd0, m_reg(1)});
        chk("cmp_div_busy", {7'd0, div_busy}, {7'd0, m_busy()});
    end

    task automatic put(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic w, input logic [4:0] rn, input logic ld,
                       input logic br, input logic dv, input logic hl);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_wreg = w;
        id_rn = rn; id_is_load = ld; id_is_branch = br; id_is_div = dv; id_is_hilo = hl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        #2 reset = 1'b0;
        put(1, 1, 2, 1, 1, 1, 4, 0, 1, 1, 1);
        @(negedge clk);
        chk("rst_stall", {7'd0, stall}, 8'd0);
        chk("rst_div_busy", {7'd0, div_busy}, 8'd0);
        chk("rst_exe_reg", {3'd0, exe_reg}, 8'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        // load-use: lw $8 ; add $9,$8,$8
        put(1, 1, 0, 1, 0, 1, 8, 1, 0, 0, 0);
        @(negedge clk);
        chk("lu_first_no_stall", {7'd0, stall}, 8'd0);
        tick();
        put(1, 8, 8, 1, 1, 1, 9, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_stall", {7'd0, stall}, 8'd1);
        chk("lu_bubble", {7'd0, bubble_ex}, 8'd1);
        tick();
        @(negedge clk);
        chk("lu_after_stall", {7'd0, stall}, 8'd0);
        chk("lu_fwda", {6'd0, fwda}, 8'd3);
        chk("lu_fwdb", {6'd0, fwdb}, 8'd3);
        chk("lu_mem_reg", {3'd0, mem_reg}, 8'd8);
        tick();
        flush();
        // ALU forwarding: add $3 ; sub rs=$3 ; or rt=$3 ; add $0 ; use $0
        put(1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0);
        tick();
        put(1, 3, 4, 1, 1, 1, 10, 0, 0, 0, 0);
        @(negedge clk);
        chk("alu_fwda_ex", {6'd0, fwda}, 8'd1);
        chk("alu_no_stall1", {7'd0, stall}, 8'd0);
        tick();
        put(1, 5, 3, 1, 1, 1, 11, 0, 0, 0, 0);
        @(negedge clk);
        chk("alu_fwdb_mem", {6'd0, fwdb}, 8'd2);
        chk("alu_no_stall2", {7'd0, stall}, 8'd0);
        tick();
        put(1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        put(1, 0, 0, 1, 1, 1, 12, 0, 0, 0, 0);
        @(negedge clk);
        chk("alu_r0_fwda", {6'd0, fwda}, 8'd0);
        chk("alu_r0_fwdb", {6'd0, fwdb}, 8'd0);
        tick();
        flush();
        // branch after ALU op: add $5 ; beq $5,$6
        put(1, 1, 2, 1, 1, 1, 5, 0, 0, 0, 0);
        tick();
        put(1, 5, 6, 1, 1, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("br_alu_stall", {7'd0, stall}, 8'd1);
        tick();
        @(negedge clk);
        chk("br_alu_go", {7'd0, stall}, 8'd0);
        chk("br_alu_fwda", {6'd0, fwda}, 8'd2);
        tick();
        flush();
        // branch after load: lw $5 ; beq $5,$6
        put(1, 1, 0, 1, 0, 1, 5, 1, 0, 0, 0);
        tick();
        put(1, 5, 6, 1, 1, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("br_ld_stall1", {7'd0, stall}, 8'd1);
        tick();
        @(negedge clk);
        chk("br_ld_stall2", {7'd0, stall}, 8'd1);
        chk("br_ld_fwda", {6'd0, fwda}, 8'd3);
        tick();
        @(negedge clk);
        chk("br_ld_go", {7'd0, stall}, 8'd0);
        tick();
        flush();
        // divide then mflo
        put(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("div_accept", {7'd0, stall}, 8'd0);
        tick();
        put(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 1);
        for (int i = 0; i < DIV; i++) begin
            @(negedge clk);
            chk("div_busy_hold", {7'd0, div_busy}, 8'd1);
            chk("div_mflo_stall", {7'd0, stall}, 8'd1);
            tick();
        end
        @(negedge clk);
        chk("div_done", {7'd0, div_busy}, 8'd0);
        chk("div_mflo_go", {7'd0, stall}, 8'd0);
        tick();
        flush();
        // reset in the middle of a divide
        put(1, 1, 2, 1, 1, 0, 0, 0, 0, 1, 1);
        tick();
        put(1, 1, 2, 1, 1, 1, 7, 0, 0, 0, 0);
        tick();
        put(1, 1, 2, 1, 1, 1, 9, 0, 0, 0, 0);
        tick();
        chk("mid_busy", {7'd0, div_busy}, 8'd1);
        chk("mid_exe_reg", {3'd0, exe_reg}, 8'd9);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_busy", {7'd0, div_busy}, 8'd0);
        chk("mid_rst_exe_reg", {3'd0, exe_reg}, 8'd0);
        chk("mid_rst_mem_reg", {3'd0, mem_reg}, 8'd0);
        put(1, 0, 0, 0, 0, 1, 13, 0, 0, 0, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        chk("mid_mflo_go", {7'd0, stall}, 8'd0);
        tick();
        flush();
        // randomized traffic with occasional asynchronous reset pulses
        repeat (800) begin
            put($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
                $urandom_range(0, 19) < 3);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                #1 reset = 1'b1;
            end
            tick();
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
